// File: rtl/inv_converter_pipe_pkg.sv
// Shared opcodes and sizing helper for the pipelined two's-complement sign converter.
package inv_conv_pkg;
   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_NEG  = 2'b01;
   localparam logic [1:0] OP_ABS  = 2'b10;

   function automatic int stages(input int width, input int seg_w);
      return (width + seg_w - 1) / seg_w;
   endfunction
endpackage

// File: rtl/inv_converter_pipe_if.sv
// Valid/ready request and response bundle of the sign converter.
interface inv_converter_pipe_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] data_i;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   data_o;
   logic             zero_o;

   modport master (output in_valid, op_i, data_i, out_ready,
                   input  in_ready, out_valid, data_o, zero_o);
   modport slave  (input  in_valid, op_i, data_i, out_ready,
                   output in_ready, out_valid, data_o, zero_o);
endinterface

// File: rtl/inv_converter_pipe_seg.sv
// One segment of the OR-chain negation: each cell flips its bit when any lower bit is set.
module inv_unit (
   input  logic i_a,
   input  logic i_pin,
   input  logic i_inv,
   output logic o_y,
   output logic o_pout
);
   assign o_y    = i_a ^ (i_inv & i_pin);
   assign o_pout = i_pin | i_a;
endmodule

module inv_conv_seg #(parameter int SEG_W = 8) (
   input  logic [SEG_W-1:0] i_a,
   input  logic             i_cin,
   input  logic             i_inv,
   output logic [SEG_W-1:0] o_y,
   output logic             o_cout
);
   logic [SEG_W:0] w_or;

   assign w_or[0] = i_cin;
   generate
      for (genvar i = 0; i < SEG_W; i++) begin : g_cell
         inv_unit u_cell (
            .i_a   (i_a[i]),
            .i_pin (w_or[i]),
            .i_inv (i_inv),
            .o_y   (o_y[i]),
            .o_pout(w_or[i+1])
         );
      end
   endgenerate
   assign o_cout = w_or[SEG_W];
endmodule

// File: rtl/inv_converter_pipe.sv
// Pipelined pass/negate/abs converter; one register slice per SEG_W-bit segment, full backpressure.
module inv_converter_pipe
   import inv_conv_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG_W = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 flush_i,
   inv_converter_pipe_if.slave  bus
);
   localparam int STAGES = stages(WIDTH, SEG_W);
   localparam int L      = STAGES - 1;

   logic [STAGES-1:0]            r_v, r_inv, r_sgn, r_carry;
   logic [STAGES-1:0][WIDTH-1:0] r_data;
   logic [STAGES-1:0]            w_adv, w_src_v, w_src_inv, w_src_sgn, w_cin, w_cout;
   logic [STAGES-1:0][WIDTH-1:0] w_src, w_nxt;
   logic                         w_in_fire;

   assign bus.in_ready = w_adv[0] & ~flush_i;
   assign w_in_fire    = bus.in_valid & bus.in_ready;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         localparam int LO = k * SEG_W;
         localparam int SW = (LO + SEG_W > WIDTH) ? (WIDTH - LO) : SEG_W;
         localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;
         logic [SW-1:0] w_y;

         // Stage 0 decides inv and keeps the original sign; later stages inherit both.
         if (k == 0) begin : g_head
            assign w_src_v[k]   = w_in_fire;
            assign w_src[k]     = bus.data_i;
            assign w_cin[k]     = 1'b0;
            assign w_src_inv[k] = (bus.op_i == OP_NEG) | ((bus.op_i == OP_ABS) & bus.data_i[WIDTH-1]);
            assign w_src_sgn[k] = bus.data_i[WIDTH-1];
         end else begin : g_body
            assign w_src_v[k]   = r_v[k-1];
            assign w_src[k]     = r_data[k-1];
            assign w_cin[k]     = r_carry[k-1];
            assign w_src_inv[k] = r_inv[k-1];
            assign w_src_sgn[k] = r_sgn[k-1];
         end

         if (k == L) begin : g_tail
            assign w_adv[k] = ~r_v[k] | bus.out_ready;
         end else begin : g_mid
            assign w_adv[k] = ~r_v[k] | w_adv[k+1];
         end

         inv_conv_seg #(.SEG_W(SW)) u_seg (
            .i_a   (w_src[k][LO +: SW]),
            .i_cin (w_cin[k]),
            .i_inv (w_src_inv[k]),
            .o_y   (w_y),
            .o_cout(w_cout[k])
         );
         assign w_nxt[k] = (w_src[k] & ~MASK) | (WIDTH'(w_y) << LO);
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_v     <= '0;
         r_inv   <= '0;
         r_sgn   <= '0;
         r_carry <= '0;
         r_data  <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (flush_i)       r_v[k] <= 1'b0;
            else if (w_adv[k]) r_v[k] <= w_src_v[k];
            if (w_adv[k] && w_src_v[k]) begin
               r_data[k]  <= w_nxt[k];
               r_inv[k]   <= w_src_inv[k];
               r_sgn[k]   <= w_src_sgn[k];
               r_carry[k] <= w_cout[k];
            end
         end
      end
   end

   // Negated top bit is set only for a non-zero, originally non-negative operand.
   assign bus.out_valid = r_v[L];
   assign bus.data_o    = r_inv[L] ? {~r_sgn[L] & r_carry[L], r_data[L]}
                                   : {r_data[L][WIDTH-1], r_data[L]};
   assign bus.zero_o    = r_v[L] & ~|bus.data_o;
endmodule

// File: tb/tb_inv_converter_pipe.sv
// Directed and randomized checks of inv_converter_pipe at three WIDTH/SEG_W points.
module tb_inv_converter_pipe;
   import inv_conv_pkg::*;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic flush_i = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 sys_clk = ~sys_clk;

   inv_converter_pipe_if #(.WIDTH(16)) b16 ();
   inv_converter_pipe_if #(.WIDTH(13)) b13 ();
   inv_converter_pipe_if #(.WIDTH(8))  b8  ();

   inv_converter_pipe #(.WIDTH(16), .SEG_W(8)) u_dut16 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush_i(flush_i), .bus(b16));
   inv_converter_pipe #(.WIDTH(13), .SEG_W(4)) u_dut13 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush_i(flush_i), .bus(b13));
   inv_converter_pipe #(.WIDTH(8), .SEG_W(8)) u_dut8 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush_i(flush_i), .bus(b8));

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [16:0] model_conv(input int w, input logic [1:0] op, input logic [15:0] d);
      int x;
      x = int'(d) & ((1 << w) - 1);
      if (d[w-1]) x = x - (1 << w);
      if (op == OP_NEG || (op == OP_ABS && x < 0)) x = -x;
      return 17'(x & ((1 << (w + 1)) - 1));
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge sys_clk);
      #1;
      n_chk++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b want=0", b16.out_valid); end
      n_chk++; if (b16.data_o !== 17'h0) begin n_err++; $display("FAIL rst_data got=%h want=00000", b16.data_o); end
      n_chk++; if (b16.zero_o !== 1'b0) begin n_err++; $display("FAIL rst_zero got=%b want=0", b16.zero_o); end
      sys_rst_n = 1'b1;
      #1;
      n_chk++; if (b16.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b want=1", b16.in_ready); end
      b16.in_valid = 1'b1; b16.op_i = OP_NEG; b16.data_i = 16'h0005;
      step();
      b16.in_valid = 1'b0;
      n_chk++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early got=%b want=0", b16.out_valid); end
      step();
      n_chk++; if (b16.out_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid got=%b want=1", b16.out_valid); end
      n_chk++; if (b16.data_o !== 17'h1FFFB) begin n_err++; $display("FAIL lat_data got=%h want=1fffb", b16.data_o); end
      step();
      n_chk++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_drain got=%b want=0", b16.out_valid); end
   endtask

   task automatic test_negate_b2b();
      logic [15:0] w [4] = '{16'h0001, 16'h8000, 16'h0000, 16'hFFFF};
      logic [16:0] e [4] = '{17'h1FFFF, 17'h08000, 17'h00000, 17'h00001};
      for (int i = 0; i < 5; i++) begin
         b16.in_valid = (i < 4);
         b16.op_i     = OP_NEG;
         b16.data_i   = (i < 4) ? w[i] : 16'h0;
         step();
         if (i >= 1) begin
            n_chk++; if (b16.out_valid !== 1'b1) begin n_err++; $display("FAIL neg_valid[%0d] got=%b want=1", i-1, b16.out_valid); end
            n_chk++; if (b16.data_o !== e[i-1]) begin n_err++; $display("FAIL neg_data[%0d] got=%h want=%h", i-1, b16.data_o, e[i-1]); end
            n_chk++; if (b16.zero_o !== (i == 3)) begin n_err++; $display("FAIL neg_zero[%0d] got=%b want=%b", i-1, b16.zero_o, (i == 3)); end
         end
      end
      b16.in_valid = 1'b0;
      step();
   endtask

   task automatic test_ops();
      logic [1:0]  o [3] = '{OP_ABS, OP_PASS, 2'b11};
      logic [15:0] w [3] = '{16'hFF85, 16'h8000, 16'h1234};
      logic [16:0] e [3] = '{17'h0007B, 17'h18000, 17'h01234};
      for (int i = 0; i < 4; i++) begin
         b16.in_valid = (i < 3);
         b16.op_i     = (i < 3) ? o[i] : 2'b00;
         b16.data_i   = (i < 3) ? w[i] : 16'h0;
         step();
         if (i >= 1) begin
            n_chk++; if (b16.data_o !== e[i-1] || b16.out_valid !== 1'b1) begin
               n_err++; $display("FAIL ops[%0d] got=%h v=%b want=%h", i-1, b16.data_o, b16.out_valid, e[i-1]);
            end
         end
      end
      b16.in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      logic [15:0] w [6] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060};
      logic [16:0] e [6] = '{17'h1FFF0, 17'h1FFE0, 17'h1FFD0, 17'h1FFC0, 17'h1FFB0, 17'h1FFA0};
      int ptr = 0;
      int got = 0;
      logic fire_in;
      for (int c = 0; c < 40 && got < 6; c++) begin
         b16.in_valid  = (ptr < 6);
         b16.op_i      = OP_NEG;
         b16.data_i    = (ptr < 6) ? w[ptr] : 16'h0;
         b16.out_ready = (c >= 5);
         #1;
         fire_in = b16.in_valid && b16.in_ready;
         if (c == 2 || c == 4) begin
            n_chk++; if (b16.out_valid !== 1'b1 || b16.data_o !== e[0]) begin
               n_err++; $display("FAIL bp_hold[c%0d] got=%h v=%b want=%h", c, b16.data_o, b16.out_valid, e[0]);
            end
         end
         if (c == 4) begin
            n_chk++; if (ptr != 2) begin n_err++; $display("FAIL bp_accepted got=%0d want=2", ptr); end
            n_chk++; if (b16.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", b16.in_ready); end
         end
         if (b16.out_valid && b16.out_ready) begin
            n_chk++; if (b16.data_o !== e[got]) begin n_err++; $display("FAIL bp_order[%0d] got=%h want=%h", got, b16.data_o, e[got]); end
            got++;
         end
         step();
         if (fire_in) ptr++;
      end
      n_chk++; if (got != 6) begin n_err++; $display("FAIL bp_count got=%0d want=6", got); end
      b16.in_valid = 1'b0; b16.out_ready = 1'b1;
      step();
   endtask

   task automatic test_flush_reset();
      int seen = 0;
      b16.out_ready = 1'b0; b16.op_i = OP_PASS;
      b16.in_valid = 1'b1; b16.data_i = 16'h0100; step();
      b16.data_i = 16'h0200; step();
      flush_i = 1'b1; b16.data_i = 16'h0999;
      #1;
      n_chk++; if (b16.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b want=0", b16.in_ready); end
      step();
      flush_i = 1'b0; b16.in_valid = 1'b0; b16.out_ready = 1'b1;
      n_chk++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b want=0", b16.out_valid); end
      repeat (4) begin step(); if (b16.out_valid) seen++; end
      n_chk++; if (seen != 0) begin n_err++; $display("FAIL flush_ghost got=%0d want=0", seen); end
      b16.in_valid = 1'b1; b16.data_i = 16'h0300; step();
      b16.in_valid = 1'b0; step();
      n_chk++; if (b16.out_valid !== 1'b1 || b16.data_o !== 17'h00300) begin
         n_err++; $display("FAIL flush_after got=%h v=%b want=00300", b16.data_o, b16.out_valid);
      end
      step();
      b16.out_ready = 1'b0;
      b16.in_valid = 1'b1; b16.data_i = 16'h0400; step();
      b16.data_i = 16'h0500; step();
      n_chk++; if (b16.out_valid !== 1'b1) begin n_err++; $display("FAIL rst2_pre got=%b want=1", b16.out_valid); end
      #3 sys_rst_n = 1'b0;
      #1;
      n_chk++; if (b16.out_valid !== 1'b0 || b16.data_o !== 17'h0 || b16.zero_o !== 1'b0) begin
         n_err++; $display("FAIL rst2_async got=%h v=%b z=%b want=00000/0/0", b16.data_o, b16.out_valid, b16.zero_o);
      end
      b16.in_valid = 1'b0; b16.out_ready = 1'b1;
      #2 sys_rst_n = 1'b1;
      step();
      n_chk++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL rst2_after got=%b want=0", b16.out_valid); end
   endtask

   task automatic test_random_sweep();
      logic [16:0] q13 [$];
      logic [16:0] q8 [$];
      logic [16:0] ex;
      for (int c = 0; c < 620; c++) begin
         b13.in_valid  = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
         b13.op_i      = 2'($urandom_range(0, 3));
         b13.data_i    = 13'($urandom);
         b13.out_ready = (c < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
         b8.in_valid   = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
         b8.op_i       = 2'($urandom_range(0, 3));
         b8.data_i     = 8'($urandom);
         b8.out_ready  = (c < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (b13.in_valid && b13.in_ready) q13.push_back(model_conv(13, b13.op_i, 16'(b13.data_i)));
         if (b8.in_valid && b8.in_ready)   q8.push_back(model_conv(8, b8.op_i, 16'(b8.data_i)));
         if (b13.out_valid && b13.out_ready) begin
            ex = (q13.size() > 0) ? q13.pop_front() : 17'h1ABCD;
            n_chk++; if (17'(b13.data_o) !== ex || b13.zero_o !== (ex == 17'h0)) begin
               n_err++; $display("FAIL rnd13[c%0d] got=%h z=%b want=%h", c, b13.data_o, b13.zero_o, ex);
            end
         end
         if (b8.out_valid && b8.out_ready) begin
            ex = (q8.size() > 0) ? q8.pop_front() : 17'h1ABCD;
            n_chk++; if (17'(b8.data_o) !== ex || b8.zero_o !== (ex == 17'h0)) begin
               n_err++; $display("FAIL rnd8[c%0d] got=%h z=%b want=%h", c, b8.data_o, b8.zero_o, ex);
            end
         end
         step();
      end
      n_chk++; if (q13.size() != 0) begin n_err++; $display("FAIL rnd13_drain got=%0d want=0", q13.size()); end
      n_chk++; if (q8.size() != 0) begin n_err++; $display("FAIL rnd8_drain got=%0d want=0", q8.size()); end
   endtask

   initial begin
      b16.in_valid = 1'b0; b16.op_i = 2'b00; b16.data_i = '0; b16.out_ready = 1'b1;
      b13.in_valid = 1'b0; b13.op_i = 2'b00; b13.data_i = '0; b13.out_ready = 1'b1;
      b8.in_valid  = 1'b0; b8.op_i  = 2'b00; b8.data_i  = '0; b8.out_ready  = 1'b1;
      test_reset();
      test_negate_b2b();
      test_ops();
      test_backpressure();
      test_flush_reset();
      test_random_sweep();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
